mem_arbiter: RTL and testbench

Multi-cycle arbiter that shares one single-port, fixed-latency unified memory between the instruction-fetch path and the load/store path of the RV32 core. It sits between the core's IF/MEM stages and the memory macro. It serialises requests, applies alternating priority on contention, and returns read data with a one-cycle acknowledge that the core uses to release its stall. Store byte enables arrive already decoded (sb=0001, sh=0011, sw=1111) from the main controller.

---
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port, fixed-latency memory between the fetch and load/store
// ports: one transaction at a time, alternating priority on contention.
module mem_arbiter #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic [31:0] dm_addr,
    input  logic [3:0]  dm_w_en,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_w_en,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int CW = (LAT > 1) ? $clog2(LAT) + 1 : 1;

    state_t        state, state_nxt;
    logic          last_dm;   // last grant went to the data port
    logic          gnt_dm;    // current transaction belongs to the data port
    logic          pick_dm;
    logic          cnt_last;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    wen_q;

    // Data wins when it is the only requester, or on a tie when fetch went last.
    assign pick_dm  = dm_req && (!if_req || !last_dm);
    assign cnt_last = (cnt == CW'(LAT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (if_req || dm_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = (wen_q != 4'b0000) ? DONE : WAIT;
            WAIT:    if (cnt_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_dm  <= 1'b0;
            gnt_dm   <= 1'b0;
            cnt      <= '0;
            addr_q   <= '0;
            wen_q    <= '0;
            wdata_q  <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (if_req || dm_req) begin
                    gnt_dm  <= pick_dm;
                    last_dm <= pick_dm;
                    addr_q  <= pick_dm ? dm_addr  : if_addr;
                    wen_q   <= pick_dm ? dm_w_en  : 4'b0000;
                    wdata_q <= pick_dm ? dm_wdata : 32'h0;
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt_last) begin
                        if (gnt_dm) dm_rdata <= mem_rdata;
                        else        if_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
            // gnt_dm only changes in IDLE, where DONE is never next.
            if_ack <= (state_nxt == DONE) && !gnt_dm;
            dm_ack <= (state_nxt == DONE) &&  gnt_dm;
        end
    end

    assign mem_en    = (state == ISSUE);
    assign mem_w_en  = mem_en ? wen_q : 4'b0000;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiters (LAT=2,4,1), each behind a fixed-latency memory
// model whose read data is only valid in the exact return cycle.
module tb_mem_arbiter;
    logic clk;
    int   checks = 0;
    int   failures = 0;
    int   n;

    logic        rst [3];
    logic        if_req [3];
    logic [31:0] if_addr [3];
    logic        if_ack [3];
    logic [31:0] if_rdata [3];
    logic        dm_req [3];
    logic [31:0] dm_addr [3];
    logic [3:0]  dm_w_en [3];
    logic [31:0] dm_wdata [3];
    logic        dm_ack [3];
    logic [31:0] dm_rdata [3];
    logic        mem_en [3];
    logic [31:0] mem_addr [3];
    logic [3:0]  mem_w_en [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];
    logic        busy [3];

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a == 32'h40) ? 32'h0050_0093 : (a ^ 32'h1357_9BDF);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : (g == 1) ? 4 : 1;
        logic [31:0] pipe [L];

        mem_arbiter #(.LAT(L)) dut (
            .clk(clk), .rst(rst[g]),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
            .dm_req(dm_req[g]), .dm_addr(dm_addr[g]), .dm_w_en(dm_w_en[g]), .dm_wdata(dm_wdata[g]),
            .dm_ack(dm_ack[g]), .dm_rdata(dm_rdata[g]),
            .mem_en(mem_en[g]), .mem_addr(mem_addr[g]), .mem_w_en(mem_w_en[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );

        // Junk everywhere except LAT cycles after the strobe.
        always @(posedge clk) begin
            pipe[0] <= mem_en[g] ? mdata(mem_addr[g]) : 32'hBAD0_BAD0;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[g] = pipe[L-1];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0; dm_req[k] = 1'b0;
            dm_addr[k] = '0; dm_w_en[k] = '0; dm_wdata[k] = '0;
        end
        // reset with both requests pending
        if_req[0] = 1'b1; if_addr[0] = 32'h0;
        dm_req[0] = 1'b1; dm_addr[0] = 32'h200; dm_w_en[0] = 4'b0000; dm_wdata[0] = 32'h1111_2222;
        step(); step();
        chk("rst_if_ack", {31'b0, if_ack[0]}, 0);
        chk("rst_dm_ack", {31'b0, dm_ack[0]}, 0);
        chk("rst_mem_en", {31'b0, mem_en[0]}, 0);
        chk("rst_mem_w_en", {28'b0, mem_w_en[0]}, 0);
        chk("rst_mem_addr", mem_addr[0], 0);
        chk("rst_mem_wdata", mem_wdata[0], 0);
        chk("rst_busy", {31'b0, busy[0]}, 0);
        chk("rst_if_rdata", if_rdata[0], 0);
        chk("rst_dm_rdata", dm_rdata[0], 0);
        rst[0] = 1'b0; rst[1] = 1'b0; rst[2] = 1'b0;

        // contention: data, fetch, data, fetch
        n = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 1) chk("first_grant_addr", mem_addr[0], 32'h200);
            chk("ack_exclusive", {31'b0, if_ack[0] && dm_ack[0]}, 0);
            if (if_ack[0] || dm_ack[0]) begin
                n++;
                chk("ack_order_is_dm", {31'b0, dm_ack[0]}, {31'b0, n[0]});
                if (dm_ack[0]) chk("cont_dm_rdata", dm_rdata[0], mdata(32'h200));
                else           chk("cont_if_rdata", if_rdata[0], mdata(32'h0));
                if (n == 4) begin if_req[0] = 1'b0; dm_req[0] = 1'b0; end
            end
        end
        chk("cont_ack_count", n, 4);

        // single fetch, LAT=2
        if_req[0] = 1'b1; if_addr[0] = 32'h40;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("fetch_mem_en", {31'b0, mem_en[0]}, {31'b0, k == 1});
            if (k == 1) begin
                chk("fetch_mem_addr", mem_addr[0], 32'h40);
                chk("fetch_mem_w_en", {28'b0, mem_w_en[0]}, 0);
            end
            chk("fetch_if_ack", {31'b0, if_ack[0]}, {31'b0, k == 4});
            chk("fetch_dm_ack", {31'b0, dm_ack[0]}, 0);
            if (k == 4) if_req[0] = 1'b0;
        end
        chk("fetch_if_rdata", if_rdata[0], 32'h0050_0093);

        // store word
        dm_req[0] = 1'b1; dm_addr[0] = 32'h100; dm_w_en[0] = 4'b1111; dm_wdata[0] = 32'hDEAD_BEEF;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("st_mem_en", {31'b0, mem_en[0]}, {31'b0, k == 1});
            chk("st_mem_w_en", {28'b0, mem_w_en[0]}, (k == 1) ? 32'hF : 32'h0);
            if (k == 1) begin
                chk("st_mem_addr", mem_addr[0], 32'h100);
                chk("st_mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
            end
            chk("st_dm_ack", {31'b0, dm_ack[0]}, {31'b0, k == 2});
            if (k == 2) begin dm_req[0] = 1'b0; dm_w_en[0] = 4'b0000; end
            if (k == 3) chk("st_busy_idle", {31'b0, busy[0]}, 0);
        end
        chk("st_dm_rdata_kept", dm_rdata[0], mdata(32'h200));
        chk("st_if_rdata_kept", if_rdata[0], 32'h0050_0093);

        // reset in the middle of WAIT, LAT=4
        dm_req[1] = 1'b1; dm_addr[1] = 32'h300; dm_w_en[1] = 4'b0000;
        step(); step(); step();
        chk("mw_busy_before", {31'b0, busy[1]}, 1);
        rst[1] = 1'b1; dm_req[1] = 1'b0;
        step();
        chk("mw_busy_after", {31'b0, busy[1]}, 0);
        chk("mw_dm_ack", {31'b0, dm_ack[1]}, 0);
        chk("mw_mem_en", {31'b0, mem_en[1]}, 0);
        rst[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mw_no_ack", {31'b0, dm_ack[1]}, 0);
        end
        chk("mw_dm_rdata", dm_rdata[1], 0);

        // LAT=1 back-to-back fetches, new address presented on the ack edge
        if_req[2] = 1'b1; if_addr[2] = 32'h0;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("b2b_dm_ack", {31'b0, dm_ack[2]}, 0);
            if (if_ack[2]) begin
                n++;
                if (n == 1) begin
                    chk("b2b_ack1_cycle", k, 3);
                    chk("b2b_rdata1", if_rdata[2], mdata(32'h0));
                    if_addr[2] = 32'h4;
                end else begin
                    chk("b2b_ack2_cycle", k, 7);
                    chk("b2b_rdata2", if_rdata[2], mdata(32'h4));
                    if_req[2] = 1'b0;
                end
            end
        end
        chk("b2b_ack_count", n, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
